intr_controller: RTL and testbench
==================================

// Module: intr_controller
// PURPOSE
//  Memory-mapped priority interrupt controller between the I/O devices (timer, keys, switches) and the CPU.
//  Edge-detects per-source request lines, latches them as pending, masks them, and selects the lowest-index
//  enabled source. Sequences a single interrupt to the CPU through an intr/intrAck/intrDone handshake.
//  Sits on the shared aBus/dBus/wrtEn I/O bus beside the timer and other devices.
// PARAMETERS
//  ABUS_WIDTH   32            address bus width
//  DBUS_WIDTH   32            data bus width
//  NUM_SRC      4             number of request sources, 1..16; index 0 = highest priority
//  BASE_ADDR    32'hF0000200  IMASK at BASE+0, IPEND at BASE+4, ISTAT at BASE+8
//  ACK_TIMEOUT  1024          cycles allowed in PEND before abort (INTR_TIMEOUT_EN only)
// PORTS
//  clk       in     1           system clock, all state on posedge
//  reset     in     1           asynchronous, active-low reset (0 = reset)
//  aBus      in     ABUS_WIDTH  I/O address
//  dBus      inout  DBUS_WIDTH  I/O data; driven only on a read hit, else 'z
//  wrtEn     in     1           1 = bus write, 0 = bus read
//  irqReq    in     NUM_SRC     device request levels (device ready & its IE bit)
//  intrAck   in     1           CPU took the interrupt (1-cycle pulse)
//  intrDone  in     1           CPU finished the handler, RETI (1-cycle pulse)
//  intr      out    1           interrupt request to CPU, registered
//  intrId    out    4           source index being signalled/serviced, registered
// BEHAVIOUR
//  Reset: IMASK=0, IPEND=0, irqReq_d=0, state=IDLE, intr=0, intrId=0, err=0, timeout cnt=0.
//  A source held high through reset release pends on the first clock.
//  IMASK [NUM_SRC-1:0]: per-source enable. Bit 31 = GIE. R/W. Other bits read 0.
//  IPEND [NUM_SRC-1:0]: set on a rise (irqReq & ~irqReq_d). Set is independent of mask.
//    Bus write: a 1 clears the bit (W1C).
//  ISTAT: [3:0]=intrId, [5:4]=state (0 IDLE, 1 PEND, 2 SERVICE), [8]=timeout err. Read-only.
//  Bus reads are combinational; a write takes effect on the clock edge.
//  Set-vs-clear on the same bit in the same cycle (W1C or ack): set wins.
//  FSM:
//   IDLE -> PEND when GIE && |(IPEND & IMASK).
//     Latch intrId = lowest set index. intr=1 from that edge.
//   PEND, intrAck -> SERVICE. Clear IPEND[intrId]; intr=0 next edge.
//   PEND, write clears GIE -> IDLE. intr=0; IPEND untouched; no ack consumed.
//     intrAck in the same cycle wins.
//   SERVICE, intrDone -> IDLE. New events keep pending while in SERVICE.
//  Latency: rise -> intr high = 2 edges (pend edge, then select edge).
//  Back-to-back interrupts have at least 1 IDLE cycle between intrDone and the next intr.
//  intrAck outside PEND and intrDone outside SERVICE are ignored.
//  intrId holds its value in IDLE until the next selection.
//  Unused mask/pend bits (>= NUM_SRC) read 0 and ignore writes.
// CONFIGURATION
//  INTR_TIMEOUT_EN defined:
//   - Counter runs in PEND and is cleared on entry.
//   - At ACK_TIMEOUT-1 with no intrAck: intr=0, -> IDLE, ISTAT[8]=1 (sticky; W1C via ISTAT write bit 8).
//   - The pending bit is retained, so the source is re-offered.
//  INTR_TIMEOUT_EN undefined: PEND waits forever; ISTAT[8] reads 0; no counter logic.
// TESTING
//  1 Reset low mid-PEND -> intr=0, state IDLE, IMASK/IPEND=0 asynchronously.
//  2 IMASK=0x8000_0001, pulse irqReq[0] -> IPEND=1, intr=1 two edges later, intrId=0;
//    intrAck -> IPEND=0, ISTAT[5:4]=2; intrDone -> IDLE.
//  3 IMASK=0x8000_000F, irqReq rises 0b1010 together -> intrId=1 first;
//    after ack/done, intrId=3 after 1 IDLE cycle.
//  4 GIE=0, rise irqReq[2] -> IPEND=0x4, intr stays 0; write IMASK=0x8000_0004 -> intr=1, intrId=2;
//    W1C IPEND=0x4 coincident with new rise -> bit remains 1.
//  5 In PEND, write IMASK=0x0000_000F -> intr=0, IDLE, IPEND unchanged.
//    intrAck in SERVICE is ignored; intrDone in IDLE is ignored.
//  6 INTR_TIMEOUT_EN, ACK_TIMEOUT=8, no ack -> intr drops after 8 cycles in PEND, ISTAT[8]=1,
//    re-offered next IDLE cycle.

Source files
------------

// File: rtl/intr_controller.sv
// ----------------------------------------------------------------------------
// intr_controller
//   Memory-mapped priority interrupt controller between the I/O devices and
//   the CPU. Rising edges on irqReq are latched into IPEND (independent of the
//   mask). When the global enable (GIE) is set and any pending source is also
//   enabled in IMASK, the lowest-index source is selected. It is then offered
//   to the CPU through the intr / intrAck / intrDone handshake.
//
//   Register map (word addresses relative to BASE_ADDR):
//     +0 IMASK : [NUM_SRC-1:0] per-source enable, [31] GIE          (R/W)
//     +4 IPEND : [NUM_SRC-1:0] pending, write 1 to clear            (R/W1C)
//     +8 ISTAT : [3:0] intrId, [5:4] state, [8] timeout error       (RO, [8] W1C)
//
//   Optional feature macro: INTR_TIMEOUT_EN
//     When defined, an interrupt left unacknowledged for ACK_TIMEOUT cycles is
//     withdrawn. The source stays pending and sticky ISTAT[8] is set.
//     When undefined, PEND waits forever and ISTAT[8] reads 0.
//
// Ports
//   clk       in     system clock, all state on posedge
//   reset     in     asynchronous active-low reset
//   aBus      in     I/O address
//   dBus      inout  I/O data, driven only on a read hit
//   wrtEn     in     1 = bus write, 0 = bus read
//   irqReq    in     per-source request levels
//   intrAck   in     CPU accepted the interrupt (1-cycle pulse)
//   intrDone  in     CPU finished the handler (1-cycle pulse)
//   intr      out    registered interrupt request to the CPU
//   intrId    out    registered index of the signalled/serviced source
// ----------------------------------------------------------------------------
module intr_controller #(
   parameter int                    ABUS_WIDTH  = 32,
   parameter int                    DBUS_WIDTH  = 32,
   parameter int                    NUM_SRC     = 4,
   parameter logic [ABUS_WIDTH-1:0] BASE_ADDR   = 32'hF000_0200,
   parameter int                    ACK_TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ABUS_WIDTH-1:0] aBus,
   inout  wire  [DBUS_WIDTH-1:0] dBus,
   input  logic                  wrtEn,
   input  logic [NUM_SRC-1:0]    irqReq,
   input  logic                  intrAck,
   input  logic                  intrDone,
   output logic                  intr,
   output logic [3:0]            intrId
);

   localparam logic [ABUS_WIDTH-1:0] A_IMASK = BASE_ADDR;
   localparam logic [ABUS_WIDTH-1:0] A_IPEND = BASE_ADDR + ABUS_WIDTH'(32'd4);
   localparam logic [ABUS_WIDTH-1:0] A_ISTAT = BASE_ADDR + ABUS_WIDTH'(32'd8);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PEND    = 2'd1,
      S_SERVICE = 2'd2
   } state_t;

   // Lowest set index wins; scanning downward lets the last hit be the lowest.
   function automatic logic [3:0] f_lowest(input logic [NUM_SRC-1:0] v);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = 4'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_gie;
   logic [NUM_SRC-1:0]   r_mask;
   logic [NUM_SRC-1:0]   r_pend;
   logic [NUM_SRC-1:0]   r_req_d;
   logic                 r_intr;
   logic [3:0]           r_intr_id;

   logic                 w_wr_mask;
   logic                 w_wr_pend;
   logic                 w_rd_hit;
   logic [NUM_SRC-1:0]   w_rise;
   logic [NUM_SRC-1:0]   w_active;
   logic                 w_sel;
   logic                 w_ack;
   logic                 w_gie_off;
   logic                 w_timeout;
   logic                 w_err;
   logic [NUM_SRC-1:0]   w_pend_clr;
   logic [DBUS_WIDTH-1:0] w_rdata;
   logic                 w_unused_bus;

   assign w_wr_mask = wrtEn && (aBus == A_IMASK);
   assign w_wr_pend = wrtEn && (aBus == A_IPEND);
   assign w_rd_hit  = !wrtEn && ((aBus == A_IMASK) || (aBus == A_IPEND) || (aBus == A_ISTAT));
   assign w_rise    = irqReq & ~r_req_d;
   assign w_active  = r_pend & r_mask;
   assign w_sel     = r_gie && (|w_active);
   assign w_ack     = (r_state == S_PEND) && intrAck;
   assign w_gie_off = w_wr_mask && !dBus[31];
   // Only a few data bits are consumed on writes; the rest are don't-care.
   assign w_unused_bus = ^dBus;

`ifdef INTR_TIMEOUT_EN
   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

   logic [CNT_W-1:0] r_to_cnt;
   logic             r_err;
   logic             w_wr_stat;

   assign w_wr_stat = wrtEn && (aBus == A_ISTAT);
   // The expiry cycle is the ACK_TIMEOUT-th cycle spent in PEND; ack still wins.
   assign w_timeout = (r_state == S_PEND) && !intrAck &&
                      (r_to_cnt == CNT_W'(ACK_TIMEOUT - 1));
   assign w_err     = r_err;

   // Acknowledge timeout counter, zero everywhere except while in PEND.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_to_cnt <= '0;
      end else if (r_state == S_PEND) begin
         r_to_cnt <= r_to_cnt + CNT_W'(1'b1);
      end else begin
         r_to_cnt <= '0;
      end
   end

   // Sticky timeout error flag; a new timeout beats a simultaneous clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err <= 1'b0;
      end else if (w_timeout) begin
         r_err <= 1'b1;
      end else if (w_wr_stat && dBus[8]) begin
         r_err <= 1'b0;
      end else begin
         r_err <= r_err;
      end
   end
`else
   logic w_unused_to;

   assign w_timeout   = 1'b0;
   assign w_err       = 1'b0;
   assign w_unused_to = (ACK_TIMEOUT > 32'sd1);
`endif

   // Pending-bit clear sources: W1C bus write and the acknowledged source.
   always_comb begin
      w_pend_clr = '0;
      if (w_wr_pend) begin
         w_pend_clr = dBus[NUM_SRC-1:0];
      end else begin
         w_pend_clr = '0;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
         if (w_ack && (r_intr_id == 4'(i))) begin
            w_pend_clr[i] = 1'b1;
         end else begin
            w_pend_clr[i] = w_pend_clr[i];
         end
      end
   end

   // Mask/GIE register and request-edge history.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mask  <= '0;
         r_gie   <= 1'b0;
         r_req_d <= '0;
      end else begin
         r_req_d <= irqReq;
         if (w_wr_mask) begin
            r_mask <= dBus[NUM_SRC-1:0];
            r_gie  <= dBus[31];
         end else begin
            r_mask <= r_mask;
            r_gie  <= r_gie;
         end
      end
   end

   // Pending register; a new rise overrides any clear in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pend <= '0;
      end else begin
         r_pend <= (r_pend & ~w_pend_clr) | w_rise;
      end
   end

   // Handshake state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Handshake next-state logic; in PEND an ack beats a GIE clear or timeout.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_sel) begin
               w_state_nxt = S_PEND;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_PEND: begin
            if (intrAck) begin
               w_state_nxt = S_SERVICE;
            end else if (w_gie_off || w_timeout) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_PEND;
            end
         end
         S_SERVICE: begin
            if (intrDone) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_SERVICE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // intr is high exactly while in PEND; intrId is latched only on selection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_intr    <= 1'b0;
         r_intr_id <= 4'd0;
      end else begin
         r_intr <= (w_state_nxt == S_PEND);
         if ((r_state == S_IDLE) && w_sel) begin
            r_intr_id <= f_lowest(w_active);
         end else begin
            r_intr_id <= r_intr_id;
         end
      end
   end

   // Combinational register read mux.
   always_comb begin
      w_rdata = '0;
      if (aBus == A_IMASK) begin
         w_rdata[NUM_SRC-1:0] = r_mask;
         w_rdata[31]          = r_gie;
      end else if (aBus == A_IPEND) begin
         w_rdata[NUM_SRC-1:0] = r_pend;
      end else if (aBus == A_ISTAT) begin
         w_rdata[3:0] = r_intr_id;
         w_rdata[5:4] = r_state;
         w_rdata[8]   = w_err;
      end else begin
         w_rdata = '0;
      end
   end

   assign dBus   = w_rd_hit ? w_rdata : {DBUS_WIDTH{1'bz}};
   assign intr   = r_intr;
   assign intrId = r_intr_id;

endmodule

// File: tb/tb_intr_controller.sv
// ----------------------------------------------------------------------------
// tb_intr_controller
//   Directed bench for intr_controller. Expected values are queued as stimulus
//   is applied and popped against DUT observations.
// ----------------------------------------------------------------------------
module tb_intr_controller;

   localparam logic [31:0] A_MASK = 32'hF000_0200;
   localparam logic [31:0] A_PEND = 32'hF000_0204;
   localparam logic [31:0] A_STAT = 32'hF000_0208;

   logic        clk;
   logic        reset;
   logic [31:0] aBus;
   wire  [31:0] dBus;
   logic        wrtEn;
   logic [3:0]  irqReq;
   logic        intrAck;
   logic        intrDone;
   logic        intr;
   logic [3:0]  intrId;

   logic        r_drv;
   logic [31:0] r_wdata;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   checks;
   int   errors;

   assign dBus = r_drv ? r_wdata : {32{1'bz}};

   intr_controller #(
      .ABUS_WIDTH (32),
      .DBUS_WIDTH (32),
      .NUM_SRC    (4),
      .BASE_ADDR  (32'hF000_0200),
      .ACK_TIMEOUT(8)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .aBus    (aBus),
      .dBus    (dBus),
      .wrtEn   (wrtEn),
      .irqReq  (irqReq),
      .intrAck (intrAck),
      .intrDone(intrDone),
      .intr    (intr),
      .intrId  (intrId)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      aBus    = addr;
      wrtEn   = 1'b1;
      r_wdata = data;
      r_drv   = 1'b1;
      step(1);
      wrtEn   = 1'b0;
      r_drv   = 1'b0;
      aBus    = 32'd0;
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] d);
      aBus  = addr;
      wrtEn = 1'b0;
      r_drv = 1'b0;
      #1;
      d     = dBus;
      aBus  = 32'd0;
   endtask

   task automatic expect_val(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.exp = v;
      sb_q.push_back(e);
   endtask

   task automatic check_obs(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $error("FAIL sb_empty observed=%h expected=none", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic chk_reg(input string tag, input logic [31:0] addr, input logic [31:0] v);
      logic [31:0] d;
      expect_val(tag, v);
      bus_read(addr, d);
      check_obs(d);
   endtask

   task automatic chk_sig(input string tag, input logic [31:0] obs, input logic [31:0] v);
      expect_val(tag, v);
      check_obs(obs);
   endtask

   task automatic pulse_ack();
      intrAck = 1'b1;
      step(1);
      intrAck = 1'b0;
   endtask

   task automatic pulse_done();
      intrDone = 1'b1;
      step(1);
      intrDone = 1'b0;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b0;
      aBus     = 32'd0;
      wrtEn    = 1'b0;
      irqReq   = 4'd0;
      intrAck  = 1'b0;
      intrDone = 1'b0;
      r_drv    = 1'b0;
      r_wdata  = 32'd0;

      // Reset state
      step(2);
      chk_reg("rst_imask", A_MASK, 32'd0);
      chk_reg("rst_ipend", A_PEND, 32'd0);
      chk_reg("rst_istat", A_STAT, 32'd0);
      chk_sig("rst_intr", 32'(intr), 32'd0);
      chk_sig("rst_intrid", 32'(intrId), 32'd0);
      reset = 1'b1;
      step(1);

      // Single source: latency, ack, done
      bus_write(A_MASK, 32'h8000_0001);
      irqReq = 4'b0001;
      expect_val("t2_ipend", 32'd1);
      expect_val("t2_intr_edge1", 32'd0);
      step(1);
      irqReq = 4'b0000;
      bus_read(A_PEND, r_wdata);
      check_obs(r_wdata);
      check_obs(32'(intr));
      step(1);
      chk_sig("t2_intr", 32'(intr), 32'd1);
      chk_sig("t2_intrid", 32'(intrId), 32'd0);
      chk_reg("t2_istat_pend", A_STAT, 32'h10);
      pulse_ack();
      chk_reg("t2_ipend_ack", A_PEND, 32'd0);
      chk_reg("t2_istat_svc", A_STAT, 32'h20);
      chk_sig("t2_intr_svc", 32'(intr), 32'd0);
      pulse_done();
      chk_reg("t2_istat_idle", A_STAT, 32'h00);

      // Two simultaneous sources: priority and IDLE gap
      bus_write(A_MASK, 32'h8000_000F);
      irqReq = 4'b1010;
      step(1);
      chk_reg("t3_ipend", A_PEND, 32'hA);
      step(1);
      chk_sig("t3_intr1", 32'(intr), 32'd1);
      chk_sig("t3_id1", 32'(intrId), 32'd1);
      pulse_ack();
      chk_reg("t3_ipend_ack", A_PEND, 32'h8);
      pulse_done();
      chk_sig("t3_gap_intr", 32'(intr), 32'd0);
      chk_reg("t3_gap_istat", A_STAT, 32'h01);
      step(1);
      chk_sig("t3_intr3", 32'(intr), 32'd1);
      chk_sig("t3_id3", 32'(intrId), 32'd3);
      pulse_ack();
      pulse_done();
      chk_reg("t3_id_hold", A_STAT, 32'h03);

      // GIE off: pend without intr; enabling later; W1C vs set
      irqReq = 4'b0000;
      bus_write(A_MASK, 32'h0000_0000);
      irqReq = 4'b0100;
      step(2);
      chk_reg("t4_ipend", A_PEND, 32'h4);
      chk_sig("t4_intr_off", 32'(intr), 32'd0);
      bus_write(A_MASK, 32'h8000_0004);
      chk_sig("t4_intr_wr_edge", 32'(intr), 32'd0);
      step(1);
      chk_sig("t4_intr", 32'(intr), 32'd1);
      chk_sig("t4_id", 32'(intrId), 32'd2);
      irqReq = 4'b0000;
      step(1);
      irqReq = 4'b0100;
      bus_write(A_PEND, 32'h4);
      chk_reg("t4_set_wins", A_PEND, 32'h4);
      bus_write(A_PEND, 32'h4);
      chk_reg("t4_w1c", A_PEND, 32'h0);
      chk_sig("t4_still_pend", 32'(intr), 32'd1);
      pulse_ack();
      pulse_done();
      irqReq = 4'b0000;

      // Unused register bits
      bus_write(A_MASK, 32'hFFFF_FFFF);
      chk_reg("unused_mask", A_MASK, 32'h8000_000F);
      bus_write(A_PEND, 32'hFFFF_FFFF);
      chk_reg("unused_pend", A_PEND, 32'h0);
      chk_sig("unused_intr", 32'(intr), 32'd0);

      // GIE clear in PEND; ignored ack/done
      irqReq = 4'b0010;
      step(2);
      chk_sig("t5_intr", 32'(intr), 32'd1);
      chk_sig("t5_id", 32'(intrId), 32'd1);
      irqReq = 4'b0000;
      bus_write(A_MASK, 32'h0000_000F);
      chk_sig("t5_intr_off", 32'(intr), 32'd0);
      chk_reg("t5_istat", A_STAT, 32'h01);
      chk_reg("t5_ipend", A_PEND, 32'h2);
      pulse_done();
      chk_reg("t5_done_ignored", A_STAT, 32'h01);
      bus_write(A_MASK, 32'h8000_000F);
      step(1);
      chk_sig("t5_reoffer", 32'(intr), 32'd1);
      pulse_ack();
      chk_reg("t5_svc", A_STAT, 32'h21);
      pulse_ack();
      chk_reg("t5_ack_ignored", A_STAT, 32'h21);
      pulse_done();
      chk_reg("t5_idle", A_STAT, 32'h01);

      // Ack coincident with GIE clear: ack wins
      irqReq = 4'b0001;
      step(2);
      chk_sig("ackwin_intr", 32'(intr), 32'd1);
      intrAck = 1'b1;
      bus_write(A_MASK, 32'h0000_000F);
      intrAck = 1'b0;
      chk_reg("ackwin_istat", A_STAT, 32'h20);
      pulse_done();

      // Reset asserted mid-PEND; source held through reset release
      irqReq = 4'b0000;
      bus_write(A_MASK, 32'h8000_0001);
      irqReq = 4'b0001;
      step(2);
      chk_sig("t1_intr_pend", 32'(intr), 32'd1);
      reset = 1'b0;
      #1;
      chk_sig("t1_intr_async", 32'(intr), 32'd0);
      chk_reg("t1_imask", A_MASK, 32'd0);
      chk_reg("t1_ipend", A_PEND, 32'd0);
      chk_reg("t1_istat", A_STAT, 32'd0);
      step(1);
      reset = 1'b1;
      step(1);
      chk_reg("t1_held_pend", A_PEND, 32'h1);
      chk_sig("t1_no_intr", 32'(intr), 32'd0);

`ifdef INTR_TIMEOUT_EN
      // Ack timeout withdraws intr and re-offers the source
      bus_write(A_MASK, 32'h8000_0001);
      step(1);
      chk_sig("t6_enter", 32'(intr), 32'd1);
      step(7);
      chk_sig("t6_before_to", 32'(intr), 32'd1);
      step(1);
      chk_sig("t6_to_intr", 32'(intr), 32'd0);
      chk_reg("t6_to_istat", A_STAT, 32'h100);
      step(1);
      chk_sig("t6_reoffer", 32'(intr), 32'd1);
      chk_reg("t6_reoffer_istat", A_STAT, 32'h110);
      pulse_ack();
      pulse_done();
      bus_write(A_STAT, 32'h100);
      chk_reg("t6_err_w1c", A_STAT, 32'h000);
`else
      // Without the timeout option PEND waits indefinitely
      bus_write(A_MASK, 32'h8000_0001);
      step(21);
      chk_sig("nto_still_pend", 32'(intr), 32'd1);
      chk_reg("nto_istat", A_STAT, 32'h10);
      pulse_ack();
      pulse_done();
`endif

      chk_sig("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
